// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_pkg
// Purpose : Shared types and constants for the CPU/DMA memory-port arbiter.
//           Holds the arbiter state encoding, the requester identity type,
//           the default bus widths and small helpers used by mem_arbiter.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

   // Default bus widths of the CPU <-> RAM path.
   localparam int c_WORD_SIZE = 16;
   localparam int c_ADDR_SIZE = 8;

   // Arbiter FSM encoding.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_DMA  = 2'd2
   } arb_state_e;

   // Identity of a requester; used for the round-robin pointer and for the
   // read-return tag.
   typedef enum logic [0:0] {
      OWNER_CPU = 1'b0,
      OWNER_DMA = 1'b1
   } owner_e;

   // Width of a counter that must hold 0 .. max_burst-1 (at least one bit).
   function automatic int burst_cnt_width(input int max_burst);
      return (max_burst <= 2) ? 1 : $clog2(max_burst);
   endfunction

   // Tie-break from IDLE: the requester that did not own the port last wins.
   function automatic arb_state_e rr_pick(input owner_e last);
      return (last == OWNER_DMA) ? ARB_CPU : ARB_DMA;
   endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one synchronous memory port between the CPU load/store
//           path and a DMA engine. The granted requester keeps the port for
//           back-to-back accesses; while the other side waits a tenure is
//           capped at MAX_BURST accesses, and ties are broken round-robin.
//           Read data returns to the requester that issued the read, one
//           cycle after the read address was presented.
// Ports   :
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU access request
//   cpu_gnt_o                     CPU owns the port (registered)
//   cpu_rdata_o/cpu_rvalid_o      CPU read return
//   dma_*                         same set for the DMA engine
//   mem_addr_o/wdata_o/we_o       memory port, zero when no access issues
//   mem_rdata_i                   memory read data, one cycle after address
// Rev     : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WORD_W    = c_WORD_SIZE,
   parameter int ADDR_W    = c_ADDR_SIZE,
   parameter int MAX_BURST = 4            // must be >= 1
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [WORD_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic [WORD_W-1:0] cpu_rdata_o,
   output logic              cpu_rvalid_o,

   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [WORD_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic [WORD_W-1:0] dma_rdata_o,
   output logic              dma_rvalid_o,

   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WORD_W-1:0] mem_wdata_o,
   output logic              mem_we_o,
   input  logic [WORD_W-1:0] mem_rdata_i
);

   localparam int                 c_CNT_W      = burst_cnt_width(MAX_BURST);
   localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(MAX_BURST - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   arb_state_e          state_q,     state_d;
   owner_e              last_q,      last_d;
   logic [c_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic                rd_pend_q,   rd_pend_d;
   owner_e              rd_owner_q,  rd_owner_d;
   logic [WORD_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [WORD_W-1:0]   dma_rdata_q, dma_rdata_d;

   // ------------------------------------------------------------------------
   // Owner mux: the owner's request fields, and the request of the side that
   // is currently locked out (used for the forced handover).
   // ------------------------------------------------------------------------
   logic              w_owner_req;
   logic              w_other_req;
   logic              w_owner_we;
   logic [ADDR_W-1:0] w_owner_addr;
   logic [WORD_W-1:0] w_owner_wdata;
   logic              w_issue;
   logic              w_burst_last;
   logic              w_cpu_rvalid;
   logic              w_dma_rvalid;

   always_comb begin
      w_owner_req   = 1'b0;
      w_other_req   = 1'b0;
      w_owner_we    = 1'b0;
      w_owner_addr  = '0;
      w_owner_wdata = '0;
      case (state_q)
         ARB_CPU: begin
            w_owner_req   = cpu_req_i;
            w_other_req   = dma_req_i;
            w_owner_we    = cpu_we_i;
            w_owner_addr  = cpu_addr_i;
            w_owner_wdata = cpu_wdata_i;
         end
         ARB_DMA: begin
            w_owner_req   = dma_req_i;
            w_other_req   = cpu_req_i;
            w_owner_we    = dma_we_i;
            w_owner_addr  = dma_addr_i;
            w_owner_wdata = dma_wdata_i;
         end
         default: begin
         end
      endcase
   end

   // Reset blocks issue outright so nothing reaches the RAM while rst is high,
   // even though the registered grant only drops after the reset edge.
   assign w_issue      = w_owner_req & ~rst;
   assign w_burst_last = (burst_cnt_q == c_BURST_LAST);

   assign mem_we_o    = w_issue & w_owner_we;
   assign mem_addr_o  = w_issue ? w_owner_addr  : '0;
   assign mem_wdata_o = w_issue ? w_owner_wdata : '0;

   assign cpu_gnt_o = (state_q == ARB_CPU);
   assign dma_gnt_o = (state_q == ARB_DMA);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (cpu_req_i && dma_req_i) begin
               state_d = rr_pick(last_q);
            end else if (cpu_req_i) begin
               state_d = ARB_CPU;
            end else if (dma_req_i) begin
               state_d = ARB_DMA;
            end
         end
         ARB_CPU: begin
            if (!cpu_req_i) begin
               state_d = dma_req_i ? ARB_DMA : ARB_IDLE;
            end else if (w_burst_last && dma_req_i) begin
               // This cycle's access still issues; the port moves afterwards.
               state_d = ARB_DMA;
            end
         end
         ARB_DMA: begin
            if (!dma_req_i) begin
               state_d = cpu_req_i ? ARB_CPU : ARB_IDLE;
            end else if (w_burst_last && cpu_req_i) begin
               state_d = ARB_CPU;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Round-robin pointer follows whoever is being granted.
   always_comb begin
      last_d = last_q;
      if (state_d == ARB_CPU) begin
         last_d = OWNER_CPU;
      end else if (state_d == ARB_DMA) begin
         last_d = OWNER_DMA;
      end
   end

   // Burst counter: accesses in the current tenure. It saturates at the last
   // slot, so a long solo tenure hands over right after the next access once
   // the other side starts requesting.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (state_d != state_q) begin
         burst_cnt_d = '0;
      end else if (w_issue && !w_burst_last) begin
         burst_cnt_d = burst_cnt_q + c_CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Read-return pipeline: one tag stage matching the RAM's read latency.
   // The tag, not the current grant, steers the data, so a read issued on the
   // last cycle of a tenure still returns to its issuer.
   // ------------------------------------------------------------------------
   always_comb begin
      rd_pend_d  = w_issue & ~w_owner_we;
      rd_owner_d = (state_q == ARB_DMA) ? OWNER_DMA : OWNER_CPU;
   end

   // A return landing in a reset cycle is dropped.
   assign w_cpu_rvalid = rd_pend_q & (rd_owner_q == OWNER_CPU) & ~rst;
   assign w_dma_rvalid = rd_pend_q & (rd_owner_q == OWNER_DMA) & ~rst;

   // The non-target side keeps showing its last returned word.
   always_comb begin
      cpu_rdata_d = w_cpu_rvalid ? mem_rdata_i : cpu_rdata_q;
      dma_rdata_d = w_dma_rvalid ? mem_rdata_i : dma_rdata_q;
   end

   assign cpu_rvalid_o = w_cpu_rvalid;
   assign dma_rvalid_o = w_dma_rvalid;
   assign cpu_rdata_o  = cpu_rdata_d;
   assign dma_rdata_o  = dma_rdata_d;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         last_q      <= OWNER_DMA;
         burst_cnt_q <= '0;
         rd_pend_q   <= 1'b0;
         rd_owner_q  <= OWNER_CPU;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         burst_cnt_q <= burst_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rd_owner_q  <= rd_owner_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

endmodule : mem_arbiter
`default_nettype wire
